// File: rtl/ethernet_tx_frame.sv
// ethernet_tx_frame
// GMII transmit-side frame builder. Accepts a DA..payload byte stream over
// valid/ready. Emits preamble, SFD, the data, an optional zero pad, the CRC-32
// FCS and an inter-frame gap on the GMII TX pins.
// Configuration macro: ETH_TX_PAD_EN. When it is defined, frames shorter than
// MIN_LEN are zero-padded. When it is undefined, the FCS always follows the
// last data byte.
// All GMII pins are registered: a byte chosen in cycle N is on the pins at N+1.
module ethernet_tx_frame #(
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 12
) (
  input  logic       i_tx_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  input  logic       i_s_last,
  output logic       o_s_ready,
  output logic       o_tx_en,
  output logic       o_tx_er,
  output logic [7:0] o_tx_d,
  output logic [2:0] o_fsm_state,
  output logic       o_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6,
    ST_DROP = 3'd7
  } state_t;

  localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
  localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

  // The IDLE cycle that precedes every preamble also shows tx_en=0 on the
  // pins. The IFG state therefore lasts one cycle less than IFG_CYCLES.
  // This makes the gap seen on the pins exactly IFG_CYCLES when frames are
  // queued back to back.
  localparam int          IFG_STATE_CYCLES = (IFG_CYCLES > 1) ? IFG_CYCLES - 1 : 1;
  localparam logic [7:0]  IFG_LAST         = 8'(IFG_STATE_CYCLES - 1);
  localparam logic [7:0]  PRE_LAST         = 8'd6;
  localparam logic [7:0]  FCS_LAST         = 8'd3;
  localparam logic [31:0] CRC_INIT         = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL    = 32'hEDB8_8320;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;        // DA..payload(+pad) bytes sent so far
  logic [7:0]  ph_q, ph_d;          // cycle counter inside PRE / FCS / IFG
  logic [31:0] crc_q, crc_d;        // reflected CRC-32 running remainder
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic [7:0]  tx_d_q, tx_d_d;
  logic        underrun_q, underrun_d;
  logic [31:0] fcs_word;

  // One byte of the reflected CRC-32 (LSB-first bit order, as on the wire).
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [7:0]  data_in);
    logic [31:0] r;
    r = crc_in ^ {24'd0, data_in};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs_word    = ~crc_q;
  assign o_s_ready   = (state_q == ST_DATA) || (state_q == ST_DROP);
  assign o_fsm_state = state_q;
  assign o_tx_en     = tx_en_q;
  assign o_tx_er     = tx_er_q;
  assign o_tx_d      = tx_d_q;
  assign o_underrun  = underrun_q;

  // Next-state logic, plus the pin values chosen for the following cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    crc_d      = crc_q;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    tx_d_d     = 8'h00;
    underrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        crc_d = CRC_INIT;
        cnt_d = '0;
        ph_d  = '0;
        // The first data byte is not consumed here; it waits for DATA.
        if (i_s_valid) begin
          state_d = ST_PRE;
        end
      end

      ST_PRE: begin
        tx_en_d = 1'b1;
        tx_d_d  = 8'h55;
        if (ph_q == PRE_LAST) begin
          ph_d    = '0;
          state_d = ST_SFD;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      ST_SFD: begin
        tx_en_d = 1'b1;
        tx_d_d  = 8'hD5;
        state_d = ST_DATA;
      end

      ST_DATA: begin
        // A starved stream or an oversize frame aborts the frame. The abort
        // drives one error cycle onto the pins. If the offending byte was the
        // last one, the frame is complete and the rest of the frame is not
        // dropped.
        if ((cnt_q == MAX_CNT) || !i_s_valid) begin
          tx_en_d    = 1'b1;
          tx_er_d    = 1'b1;
          tx_d_d     = 8'h00;
          underrun_d = 1'b1;
          ph_d       = '0;
          state_d    = (i_s_valid && i_s_last) ? ST_IFG : ST_DROP;
        end else begin
          tx_en_d = 1'b1;
          tx_d_d  = i_s_data;
          crc_d   = crc_byte(crc_q, i_s_data);
          cnt_d   = cnt_q + 11'd1;
          if (i_s_last) begin
            ph_d = '0;
`ifdef ETH_TX_PAD_EN
            state_d = ((cnt_q + 11'd1) < MIN_CNT) ? ST_PAD : ST_FCS;
`else
            state_d = ST_FCS;
`endif
          end
        end
      end

      ST_PAD: begin
        // Zero bytes are part of the CRC coverage just like data.
        tx_en_d = 1'b1;
        tx_d_d  = 8'h00;
        crc_d   = crc_byte(crc_q, 8'h00);
        cnt_d   = cnt_q + 11'd1;
        if ((cnt_q + 11'd1) >= MIN_CNT) begin
          ph_d    = '0;
          state_d = ST_FCS;
        end
      end

      ST_FCS: begin
        // The complemented remainder is sent least significant byte first.
        tx_en_d = 1'b1;
        tx_d_d  = fcs_word[{ph_q[1:0], 3'b000} +: 8];
        if (ph_q == FCS_LAST) begin
          ph_d    = '0;
          state_d = ST_IFG;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      ST_IFG: begin
        crc_d = CRC_INIT;
        if (ph_q == IFG_LAST) begin
          ph_d    = '0;
          state_d = ST_IDLE;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      ST_DROP: begin
        // Silently swallow the remainder of an aborted frame.
        if (i_s_valid && i_s_last) begin
          ph_d    = '0;
          state_d = ST_IFG;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, CRC and the registered GMII pins. Reset clears the pins
  // at once, even in the middle of a frame.
  always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ph_q       <= '0;
      crc_q      <= CRC_INIT;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      tx_d_q     <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      crc_q      <= crc_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      tx_d_q     <= tx_d_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
